// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory slave with programmable wait states, byte strobes and out-of-range fault
module mem_responder #(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        fault
);
  localparam int AW = $clog2(WORDS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam logic [3:0] LAT  = 4'(LATENCY);
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          ok_q, ok_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem [WORDS];
  logic          to_ack;
  logic          in_range;
  logic          unused;
  assign unused    = ^{mem_instr, mem_addr[1:0]};
  assign in_range  = mem_addr[31:AW+2] == '0;
  assign mem_ready = ready_q;
  assign fault     = fault_q;
  assign mem_rdata = rdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    ok_d    = ok_q;
    to_ack  = 1'b0;
    if (state_q == IDLE && mem_valid) begin
      idx_d   = mem_addr[AW+1:2];
      wdata_d = mem_wdata;
      wstrb_d = mem_wstrb;
      ok_d    = in_range;
      cnt_d   = LAT;
      to_ack  = LAT == 4'd0;
      state_d = to_ack ? ACK : WAIT;
    end else if (state_q == WAIT) begin
      if (!mem_valid) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end else begin
        cnt_d   = cnt_q - 4'd1;
        to_ack  = cnt_q == 4'd1;
        state_d = to_ack ? ACK : WAIT;
      end
    end else if (state_q == ACK) begin
      state_d = IDLE;
    end
    ready_d = to_ack;
    fault_d = to_ack && !ok_d;
    rdata_d = (to_ack && ok_d && wstrb_d == 4'd0) ? mem[idx_d] : 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      ok_q    <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ok_q    <= ok_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (state_q == ACK && ok_q && wstrb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (LATENCY 0/1/15) exercised against an array-based memory model
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid [3];
  logic        instr [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic        ready [3];
  logic [31:0] rdata [3];
  logic        fault [3];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_mem [3][1024];
  bit   [3:0]  known     [3][1024];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(.WORDS(1024), .LATENCY(g == 0 ? 0 : (g == 1 ? 1 : 15))) u_dut (
      .clk(clk), .reset_n(reset_n), .mem_valid(valid[g]), .mem_instr(instr[g]),
      .mem_addr(addr[g]), .mem_wdata(wdata[g]), .mem_wstrb(wstrb[g]),
      .mem_ready(ready[g]), .mem_rdata(rdata[g]), .fault(fault[g]));
  end
  function automatic int lat(input int k);
    return k == 0 ? 0 : (k == 1 ? 1 : 15);
  endfunction
  task automatic xact(input int k, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input bit b2b, input bit keep, output logic [31:0] rd, output logic f);
    int n;
    int exp_n;
    bit seen;
    bit inr;
    int idx;
    logic [31:0] msk;
    valid[k] = 1'b1; addr[k] = a; wdata[k] = wd; wstrb[k] = ws; instr[k] = 1'($urandom);
    seen = 0; n = 0; rd = '0; f = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (ready[k]) begin
        seen = 1; rd = rdata[k]; f = fault[k];
      end else if (n >= (b2b ? 2 : 1)) begin
        addr[k] = $urandom; wdata[k] = $urandom; wstrb[k] = 4'($urandom);
      end
    end
    exp_n = lat(k) + 1 + (b2b ? 1 : 0);
    inr = a < 32'h1000;
    idx = int'(a[11:2]);
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL timeout dut%0d addr %h: no mem_ready within 40 cycles", k, a);
    end else begin
      if (n != exp_n) begin n_err++; $display("FAIL latency dut%0d addr %h: got %0d want %0d", k, a, n, exp_n); end
      n_cmp++;
      if (f !== !inr) begin n_err++; $display("FAIL fault dut%0d addr %h: got %b want %b", k, a, f, !inr); end
      n_cmp++;
      if (!inr || ws != 4'd0) begin
        if (rd !== 32'd0) begin n_err++; $display("FAIL rdata_zero dut%0d addr %h: got %h want 00000000", k, a, rd); end
      end else begin
        for (int b = 0; b < 4; b++) msk[8*b +: 8] = {8{known[k][idx][b]}};
        if ((rd & msk) !== (model_mem[k][idx] & msk))
          begin n_err++; $display("FAIL rdata dut%0d addr %h: got %h want %h (mask %h)", k, a, rd, model_mem[k][idx], msk); end
      end
    end
    if (seen && inr)
      for (int b = 0; b < 4; b++)
        if (ws[b]) begin model_mem[k][idx][8*b +: 8] = wd[8*b +: 8]; known[k][idx][b] = 1'b1; end
    if (!keep) begin
      valid[k] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ready[k] !== 1'b0 || fault[k] !== 1'b0 || rdata[k] !== 32'd0)
        begin n_err++; $display("FAIL after_ack dut%0d: ready %b fault %b rdata %h want 0 0 0", k, ready[k], fault[k], rdata[k]); end
    end
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b1; instr[k] = 1'b0; addr[k] = 32'h10; wdata[k] = 32'h1; wstrb[k] = 4'h0;
    end
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (ready[k] !== 1'b0 || fault[k] !== 1'b0 || rdata[k] !== 32'd0)
          begin n_err++; $display("FAIL reset dut%0d: ready %b fault %b rdata %h want 0 0 0", k, ready[k], fault[k], rdata[k]); end
      end
    end
    for (int k = 0; k < 3; k++) valid[k] = 1'b0;
    reset_n = 1'b1;
  endtask
  task automatic basic_one(input int k);
    logic [31:0] rd;
    logic f;
    xact(k, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, f);
    xact(k, 32'h10, 32'h0, 4'h0, 0, 0, rd, f);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || f !== 1'b0) begin n_err++; $display("FAIL basic dut%0d: got %h/%b want deadbeef/0", k, rd, f); end
  endtask
  task automatic test_basic();
    fork basic_one(0); basic_one(1); basic_one(2); join
  endtask
  task automatic strobe_one(input int k);
    logic [31:0] rd;
    logic f;
    xact(k, 32'h20, 32'h11223344, 4'hF, 0, 0, rd, f);
    xact(k, 32'h22, 32'hAABBCCDD, 4'h5, 0, 0, rd, f);
    xact(k, 32'h23, 32'h0, 4'h0, 0, 0, rd, f);
    n_cmp++;
    if (rd !== 32'h11BB33DD) begin n_err++; $display("FAIL strobes dut%0d: got %h want 11bb33dd", k, rd); end
  endtask
  task automatic test_strobes();
    fork strobe_one(0); strobe_one(1); strobe_one(2); join
  endtask
  task automatic range_one(input int k);
    logic [31:0] rd;
    logic f;
    xact(k, 32'h0, 32'h5A5A5A5A, 4'hF, 0, 0, rd, f);
    xact(k, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 0, rd, f);
    n_cmp++;
    if (f !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL range_wr dut%0d: got %b/%h want 1/00000000", k, f, rd); end
    xact(k, 32'h1000, 32'h0, 4'h0, 0, 0, rd, f);
    n_cmp++;
    if (f !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL range_rd dut%0d: got %b/%h want 1/00000000", k, f, rd); end
    xact(k, 32'h0, 32'h0, 4'h0, 0, 0, rd, f);
    n_cmp++;
    if (f !== 1'b0 || rd !== 32'h5A5A5A5A) begin n_err++; $display("FAIL range_w0 dut%0d: got %b/%h want 0/5a5a5a5a", k, f, rd); end
  endtask
  task automatic test_range();
    fork range_one(0); range_one(1); range_one(2); join
  endtask
  task automatic b2b_one(input int k);
    logic [31:0] rd;
    logic f;
    xact(k, 32'h50, 32'hCAFEF00D, 4'hF, 0, 1, rd, f);
    xact(k, 32'h50, 32'h0, 4'h0, 1, 1, rd, f);
    n_cmp++;
    if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b dut%0d: got %h want cafef00d", k, rd); end
    xact(k, 32'h54, 32'h0BADCAFE, 4'hF, 1, 0, rd, f);
  endtask
  task automatic test_back_to_back();
    fork b2b_one(0); b2b_one(1); b2b_one(2); join
  endtask
  task automatic abort_one(input int k);
    logic [31:0] rd;
    logic f;
    bit bad;
    xact(k, 32'h40, 32'h01234567, 4'hF, 0, 0, rd, f);
    valid[k] = 1'b1; addr[k] = 32'h40; wdata[k] = 32'hFFFFFFFF; wstrb[k] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bad = ready[k] !== 1'b0;
    valid[k] = 1'b0;
    repeat (lat(k) + 3) begin
      @(negedge clk);
      if (ready[k] !== 1'b0 || fault[k] !== 1'b0) bad = 1;
    end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL abort_ready dut%0d: got ready/fault after abort want none", k); end
    xact(k, 32'h40, 32'h0, 4'h0, 0, 0, rd, f);
    n_cmp++;
    if (rd !== 32'h01234567) begin n_err++; $display("FAIL abort_mem dut%0d: got %h want 01234567", k, rd); end
  endtask
  task automatic test_abort();
    fork abort_one(1); abort_one(2); join
  endtask
  task automatic test_reset_mid();
    logic [31:0] r0, r1, r2;
    logic f0, f1, f2;
    fork
      xact(0, 32'h30, 32'h0, 4'hF, 0, 0, r0, f0);
      xact(1, 32'h30, 32'h0, 4'hF, 0, 0, r1, f1);
      xact(2, 32'h30, 32'h0, 4'hF, 0, 0, r2, f2);
    join
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b1; addr[k] = 32'h30; wdata[k] = $urandom | 32'h1; wstrb[k] = 4'hF;
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (ready[k] !== 1'b0 || fault[k] !== 1'b0 || rdata[k] !== 32'd0)
        begin n_err++; $display("FAIL reset_async dut%0d: ready %b fault %b rdata %h want 0 0 0", k, ready[k], fault[k], rdata[k]); end
      valid[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    fork
      xact(0, 32'h30, 32'h0, 4'h0, 0, 0, r0, f0);
      xact(1, 32'h30, 32'h0, 4'h0, 0, 0, r1, f1);
      xact(2, 32'h30, 32'h0, 4'h0, 0, 0, r2, f2);
    join
    n_cmp++;
    if (r0 !== 32'd0 || r1 !== 32'd0 || r2 !== 32'd0)
      begin n_err++; $display("FAIL reset_discard: got %h %h %h want 0 0 0", r0, r1, r2); end
  endtask
  task automatic rand_one(input int k);
    logic [31:0] a, rd;
    logic [3:0] ws;
    logic f;
    bit keep, prev;
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h1000) : (32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3)));
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      keep = (i != 39) && ($urandom_range(0, 3) == 0);
      xact(k, a, $urandom, ws, prev, keep, rd, f);
      prev = keep;
    end
  endtask
  task automatic test_random();
    fork rand_one(0); rand_one(1); rand_one(2); join
  endtask
  initial begin
    test_reset();
    test_basic();
    test_strobes();
    test_range();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL use parameter WORDS, default 1024, meaning memory depth in 32-bit words (power of two, 16..65536).
REQ-002 The block SHALL use parameter LATENCY, default 1, meaning wait cycles inserted before mem_ready (0..15).
REQ-003 The block SHALL use one clock and an asynchronous active-low reset; no other clock or reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 mem_valid  input  1  request from initiator, held until mem_ready.
REQ-007 mem_instr  input  1  instruction-fetch qualifier; no functional effect.
REQ-008 mem_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 mem_wdata  input  32  write data.
REQ-010 mem_wstrb  input  4  byte write enables; 0 = read.
REQ-011 mem_ready  output  1  one-cycle completion pulse.
REQ-012 mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-013 fault  output  1  pulses with mem_ready when the address is out of range.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT, ACK.
REQ-015 IDLE with mem_valid=1 at a clock edge SHALL latch addr/wdata/wstrb, load a 4-bit counter with LATENCY, and go to WAIT; LATENCY=0 goes straight to ACK.
REQ-016 WAIT SHALL decrement the counter each edge and go to ACK on the edge where the counter reaches 0.
REQ-017 mem_ready SHALL be 1 only in ACK, exactly LATENCY+1 cycles after the acceptance edge.
REQ-018 ACK SHALL last one cycle and return to IDLE.
REQ-019 After ACK, the block SHALL spend at least one cycle in IDLE before it accepts a new request; a same-cycle re-accept is forbidden.
REQ-020 Word index SHALL be latched addr[log2(WORDS)+1:2]; the address is in range iff addr < 4*WORDS.
REQ-021 A read that is in range SHALL drive mem_rdata to the stored word during ACK.
REQ-022 A write that is in range SHALL update each byte lane i with mem_wstrb[i]=1 at the edge ending ACK; the other lanes are unchanged.
REQ-023 During ACK of a write, mem_rdata SHALL be 0.
REQ-024 An access that is out of range SHALL assert fault=1 with mem_ready, return mem_rdata=0, and not modify memory.
REQ-025 mem_rdata SHALL be registered and SHALL be 0 outside ACK.
REQ-026 If mem_valid falls while in WAIT (protocol violation), the block SHALL abort to IDLE at the next edge with no mem_ready, no write and no fault.
REQ-027 Changes to mem_addr/mem_wdata/mem_wstrb after acceptance SHALL be ignored; the latched values are used.
REQ-028 The memory array SHALL NOT be reset; contents are undefined until written.

Reset
REQ-029 When reset_n=0 the block SHALL immediately force state=IDLE, mem_ready=0, fault=0, mem_rdata=0, counter=0.
REQ-030 Reset asserted during WAIT or ACK SHALL discard the pending write; memory SHALL hold its pre-request contents.
REQ-031 After reset_n deasserts, the first accept SHALL occur no earlier than the first rising edge with reset_n=1.

Verification
REQ-032 LATENCY=1: write 0xDEADBEEF to 0x10, wstrb=0xF -> mem_ready at acceptance+2 cycles; then read 0x10 -> mem_rdata=0xDEADBEEF, fault=0.
REQ-033 Byte strobes: write 0x11223344 to 0x20 with wstrb=0xF, then 0xAABBCCDD with wstrb=0x5 -> read returns 0x11BB33DD.
REQ-034 LATENCY=0 and LATENCY=15: a read SHALL get mem_ready at exactly 1 and 16 cycles after acceptance, one cycle wide; back-to-back requests SHALL see one IDLE gap.
REQ-035 Out of range (WORDS=1024): write to 0x1000 then read 0x1000 and 0x0 -> fault=1 on both 0x1000 accesses, mem_rdata=0, word 0 unchanged.
REQ-036 Reset_n pulsed low mid-WAIT of a write to 0x30 (previously 0x0) -> mem_ready never asserts; a later read of 0x30 returns 0x0.
REQ-037 mem_valid dropped in WAIT -> no mem_ready; next request completes normally with correct latency.
